weight_buffer_ctrl: RTL and testbench

- Sequences the per-column weight FIFO bank that feeds the systolic array.
- Accepts a row-wide weight stream (one row = SYS_COLS weights) over valid/ready and writes each row into all columns.
- Tracks buffered occupancy and, on request from the array scheduler, issues a SUPER_W_ROWS-cycle read burst; the FIFO bank skews this burst across columns.
- Signals completion once the skewed burst has fully drained.

---
 rtl/weight_buffer_ctrl.sv | 154 +++++++++++++++
 tb/tb_weight_buffer_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/weight_buffer_ctrl.sv
// Weight FIFO bank sequencer: writes row-wide weights to every column FIFO and issues tile read bursts.
// Optional perf counters (stall_cycles, tiles_done) are enabled with WBC_PERF_CNT_EN.
module wbc_wr_lane #(
  parameter int W_BITWIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  accept,
  input  logic [W_BITWIDTH-1:0] din,
  output logic                  wr_en,
  output logic [W_BITWIDTH-1:0] wr_data
);
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_en   <= 1'b0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) wr_data <= din;
    end
  end
endmodule

module weight_buffer_ctrl #(
  parameter int SYS_COLS       = 4,
  parameter int W_BITWIDTH     = 8,
  parameter int W_BUFFER_DEPTH = 64,
  parameter int SUPER_W_ROWS   = 16,
  localparam int OCC_W         = $clog2(W_BUFFER_DEPTH+1)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [SYS_COLS*W_BITWIDTH-1:0] in_data,
  output logic [SYS_COLS-1:0]            wr_en,
  output logic [SYS_COLS*W_BITWIDTH-1:0] wr_data,
  output logic                           read,
  input  logic                           start_req,
  output logic                           start_ack,
  output logic                           busy,
  output logic                           done,
  output logic [OCC_W-1:0]               occupancy,
  output logic                           tile_avail
`ifdef WBC_PERF_CNT_EN
  ,
  output logic [31:0]                    stall_cycles,
  output logic [31:0]                    tiles_done
`endif
);
  localparam int ROW_W = $clog2(SUPER_W_ROWS+1);
  localparam int DRN_W = $clog2(SYS_COLS+1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(SUPER_W_ROWS-1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(SYS_COLS-1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(W_BUFFER_DEPTH);
  localparam logic [OCC_W-1:0] OCC_TILE = OCC_W'(SUPER_W_ROWS);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t             state, state_d;
  logic [ROW_W-1:0]   row_cnt, row_d;
  logic [DRN_W-1:0]   drn_cnt, drn_d;
  logic               read_d;
  logic               accept;

  assign in_ready   = (occupancy < OCC_MAX);
  assign tile_avail = (occupancy >= OCC_TILE);
  assign accept     = in_valid && in_ready;
  assign busy       = (state == READ) || (state == DRAIN);

  // Every column receives the same row; the FIFO bank applies the column skew on read.
  for (genvar c = 0; c < SYS_COLS; c++) begin : g_lane
    wbc_wr_lane #(.W_BITWIDTH(W_BITWIDTH)) u_lane (
      .clk     (clk),
      .rstn    (rstn),
      .accept  (accept),
      .din     (in_data[c*W_BITWIDTH +: W_BITWIDTH]),
      .wr_en   (wr_en[c]),
      .wr_data (wr_data[c*W_BITWIDTH +: W_BITWIDTH])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      row_cnt   <= '0;
      drn_cnt   <= '0;
      read      <= 1'b0;
      occupancy <= '0;
    end else begin
      state   <= state_d;
      row_cnt <= row_d;
      drn_cnt <= drn_d;
      read    <= read_d;
      case ({accept, read})
        2'b10:   if (occupancy < OCC_MAX) occupancy <= occupancy + OCC_W'(1);
        2'b01:   if (occupancy != '0)     occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // read is registered so it is high exactly while the FSM sits in READ.
  always_comb begin
    state_d   = state;
    row_d     = row_cnt;
    drn_d     = drn_cnt;
    read_d    = 1'b0;
    start_ack = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_req && tile_avail) begin
          start_ack = 1'b1;
          state_d   = READ;
          row_d     = '0;
          read_d    = 1'b1;
        end
      end
      READ: begin
        row_d = row_cnt + ROW_W'(1);
        if (row_cnt == ROW_LAST) begin
          state_d = DRAIN;
          drn_d   = '0;
        end else begin
          read_d = 1'b1;
        end
      end
      DRAIN: begin
        if (drn_cnt == DRN_LAST) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          drn_d = drn_cnt + DRN_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WBC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stall_cycles <= '0;
      tiles_done   <= '0;
    end else begin
      if (start_req && (state == IDLE) && !tile_avail && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
      if (done && (tiles_done != '1))
        tiles_done <= tiles_done + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// Directed bench for weight_buffer_ctrl with SYS_COLS=4, SUPER_W_ROWS=4, W_BUFFER_DEPTH=8.
module tb_weight_buffer_ctrl;
  localparam int COLS = 4, WB = 8, DEPTH = 8, SUP = 4;
  localparam int OW = $clog2(DEPTH+1);

  logic clk = 1'b0, rstn = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [COLS*WB-1:0] in_data = '0, wr_data;
  logic [COLS-1:0] wr_en;
  logic read, start_req = 1'b0, start_ack, busy, done, tile_avail;
  logic [OW-1:0] occupancy;
`ifdef WBC_PERF_CNT_EN
  logic [31:0] stall_cycles, tiles_done;
`endif
  int n_cmp = 0, n_err = 0;

  weight_buffer_ctrl #(.SYS_COLS(COLS), .W_BITWIDTH(WB), .W_BUFFER_DEPTH(DEPTH), .SUPER_W_ROWS(SUP)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .wr_en(wr_en), .wr_data(wr_data), .read(read), .start_req(start_req), .start_ack(start_ack),
    .busy(busy), .done(done), .occupancy(occupancy), .tile_avail(tile_avail)
`ifdef WBC_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .tiles_done(tiles_done)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick; @(posedge clk); #1; endtask

  task automatic apply_reset;
    in_valid = 1'b0; start_req = 1'b0; rstn = 1'b0;
    tick(); tick(); rstn = 1'b1;
  endtask

  task automatic write_rows(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      tick(); in_valid = 1'b1; in_data = base + 32'(i);
    end
    tick(); in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0; #2;
    n_cmp++; if (occupancy !== '0) begin n_err++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    n_cmp++; if (wr_en !== '0) begin n_err++; $display("FAIL reset_wr_en: got %h want 0", wr_en); end
    n_cmp++; if (wr_data !== '0) begin n_err++; $display("FAIL reset_wr_data: got %h want 0", wr_data); end
    n_cmp++; if ({read, busy, done, start_ack} !== 4'b0) begin n_err++; $display("FAIL reset_ctl: got %b want 0000", {read, busy, done, start_ack}); end
    n_cmp++; if ({in_ready, tile_avail} !== 2'b10) begin n_err++; $display("FAIL reset_flags: got %b want 10", {in_ready, tile_avail}); end
    apply_reset();
  endtask

  task automatic test_write;
    logic [31:0] row;
    for (int i = 0; i <= 4; i++) begin
      tick();
      if (i < 4) begin in_valid = 1'b1; in_data = 32'h04030201 + 32'(i); end
      else in_valid = 1'b0;
      @(negedge clk);
      if (i > 0) begin
        row = 32'h04030201 + 32'(i - 1);
        n_cmp++; if (wr_en !== 4'hF) begin n_err++; $display("FAIL wr_en_row%0d: got %h want f", i, wr_en); end
        n_cmp++; if (wr_data !== row) begin n_err++; $display("FAIL wr_data_row%0d: got %h want %h", i, wr_data, row); end
        n_cmp++; if (occupancy !== OW'(i)) begin n_err++; $display("FAIL wr_occ_row%0d: got %0d want %0d", i, occupancy, i); end
      end
    end
    tick(); @(negedge clk);
    n_cmp++; if (wr_en !== 4'h0) begin n_err++; $display("FAIL wr_en_idle: got %h want 0", wr_en); end
    n_cmp++; if (wr_data !== 32'h04030204) begin n_err++; $display("FAIL wr_data_hold: got %h want 04030204", wr_data); end
    n_cmp++; if (tile_avail !== 1'b1) begin n_err++; $display("FAIL tile_avail: got %b want 1", tile_avail); end
  endtask

  task automatic test_burst;
    tick(); start_req = 1'b1; @(negedge clk);
    n_cmp++; if ({start_ack, busy, read} !== 3'b100) begin n_err++; $display("FAIL burst_ack: got %b want 100", {start_ack, busy, read}); end
    for (int n = 1; n <= 10; n++) begin
      tick(); if (n == 1) start_req = 1'b0; @(negedge clk);
      n_cmp++; if (read !== (n <= 4)) begin n_err++; $display("FAIL burst_read_c%0d: got %b want %b", n, read, n <= 4); end
      n_cmp++; if (busy !== (n <= 8)) begin n_err++; $display("FAIL burst_busy_c%0d: got %b want %b", n, busy, n <= 8); end
      n_cmp++; if (done !== (n == 8)) begin n_err++; $display("FAIL burst_done_c%0d: got %b want %b", n, done, n == 8); end
      n_cmp++; if (occupancy !== OW'(n <= 4 ? 5 - n : 0)) begin n_err++; $display("FAIL burst_occ_c%0d: got %0d want %0d", n, occupancy, n <= 4 ? 5 - n : 0); end
    end
  endtask

  task automatic test_stall_then_ack;
    write_rows(3, 32'h11111111);
    start_req = 1'b1;
    for (int n = 0; n < 3; n++) begin
      if (n > 0) tick();
      @(negedge clk);
      n_cmp++; if ({start_ack, read, busy} !== 3'b000) begin n_err++; $display("FAIL stall_noack_c%0d: got %b want 000", n, {start_ack, read, busy}); end
    end
    tick(); in_valid = 1'b1; in_data = 32'h22222222; @(negedge clk);
    n_cmp++; if (start_ack !== 1'b0) begin n_err++; $display("FAIL stall_ack_early: got %b want 0", start_ack); end
    tick(); in_valid = 1'b0; @(negedge clk);
    n_cmp++; if ({start_ack, occupancy} !== {1'b1, OW'(4)}) begin n_err++; $display("FAIL stall_ack_late: got ack=%b occ=%0d want ack=1 occ=4", start_ack, occupancy); end
    tick(); start_req = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    n_cmp++; if ({busy, occupancy} !== {1'b0, OW'(0)}) begin n_err++; $display("FAIL stall_end: got busy=%b occ=%0d want busy=0 occ=0", busy, occupancy); end
  endtask

  task automatic test_full;
    // Expected occupancy per cycle from cycle 8: no write at 8/9, burst acked at 9, reads at 10..13.
    logic [OW-1:0] exp_occ [8:15];
    logic          exp_rdy [8:15];
    exp_occ = '{OW'(8), OW'(8), OW'(8), OW'(7), OW'(7), OW'(7), OW'(7), OW'(8)};
    exp_rdy = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    tick(); in_valid = 1'b1; in_data = 32'hA0A0A0A0;
    for (int c = 0; c <= 15; c++) begin
      if (c > 0) tick();
      if (c == 9) start_req = 1'b1;
      if (c == 10) start_req = 1'b0;
      @(negedge clk);
      if (c == 9) begin
        n_cmp++; if (start_ack !== 1'b1) begin n_err++; $display("FAIL full_ack: got %b want 1", start_ack); end
      end
      if (c >= 8) begin
        n_cmp++; if (occupancy !== exp_occ[c]) begin n_err++; $display("FAIL full_occ_c%0d: got %0d want %0d", c, occupancy, exp_occ[c]); end
        n_cmp++; if (in_ready !== exp_rdy[c]) begin n_err++; $display("FAIL full_rdy_c%0d: got %b want %b", c, in_ready, exp_rdy[c]); end
        n_cmp++; if (read !== (c >= 10 && c <= 13)) begin n_err++; $display("FAIL full_read_c%0d: got %b want %b", c, read, c >= 10 && c <= 13); end
      end
    end
    tick(); in_valid = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset_mid_burst;
    logic saw;
    apply_reset();
    write_rows(4, 32'h33333333);
    start_req = 1'b1; @(negedge clk);
    n_cmp++; if (start_ack !== 1'b1) begin n_err++; $display("FAIL rmb_ack: got %b want 1", start_ack); end
    tick(); start_req = 1'b0;
    @(posedge clk); #2;
    n_cmp++; if ({read, busy, occupancy} !== {2'b11, OW'(3)}) begin n_err++; $display("FAIL rmb_pre: got %b want 11/3", {read, busy, occupancy}); end
    rstn = 1'b0; #1;
    n_cmp++; if ({read, busy, occupancy} !== {2'b00, OW'(0)}) begin n_err++; $display("FAIL rmb_async: got read=%b busy=%b occ=%0d want 0", read, busy, occupancy); end
    tick(); rstn = 1'b1;
    saw = 1'b0;
    for (int n = 0; n < 12; n++) begin @(negedge clk); saw |= done | read | busy; tick(); end
    n_cmp++; if (saw !== 1'b0) begin n_err++; $display("FAIL rmb_no_done: got activity=%b want 0", saw); end
    start_req = 1'b1;
    write_rows(3, 32'h44444444);
    @(negedge clk);
    n_cmp++; if (start_ack !== 1'b0) begin n_err++; $display("FAIL rmb_3rows: got %b want 0", start_ack); end
    write_rows(1, 32'h55555555);
    @(negedge clk);
    n_cmp++; if (start_ack !== 1'b1) begin n_err++; $display("FAIL rmb_4rows: got %b want 1", start_ack); end
    tick(); start_req = 1'b0;
    repeat (10) tick();
  endtask

`ifdef WBC_PERF_CNT_EN
  task automatic test_perf;
    apply_reset(); @(negedge clk);
    n_cmp++; if ({stall_cycles, tiles_done} !== 64'd0) begin n_err++; $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cycles, tiles_done); end
    start_req = 1'b1;
    repeat (5) tick();
    start_req = 1'b0;
    write_rows(4, 32'h66666666);
    start_req = 1'b1; @(negedge clk);
    n_cmp++; if (start_ack !== 1'b1) begin n_err++; $display("FAIL perf_ack: got %b want 1", start_ack); end
    tick(); start_req = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    n_cmp++; if (stall_cycles !== 32'd5) begin n_err++; $display("FAIL perf_stall: got %0d want 5", stall_cycles); end
    n_cmp++; if (tiles_done !== 32'd1) begin n_err++; $display("FAIL perf_tiles: got %0d want 1", tiles_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_burst();
    test_stall_then_ack();
    test_full();
    test_reset_mid_burst();
`ifdef WBC_PERF_CNT_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
